ibex_load_wb_scoreboard: RTL and testbench

Tracks outstanding load instructions between issue from ID/EX and the LSU response, supplying the register-file write address and enable for returning load data. It also flags read-after-write hazards on pending load destinations to the ID stage. It sits beside the writeback stage and replaces the single-entry load tracking with an in-order queue of up to `Depth` loads. Responses retire strictly in issue order.

---
 rtl/ibex_load_wb_scoreboard_if.sv | 29 ++
 rtl/ibex_load_wb_scoreboard.sv | 59 +++++
 tb/tb_ibex_load_wb_scoreboard.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ibex_load_wb_scoreboard_if.sv
// ibex_load_wb_scoreboard_if: issue, response and hazard signals between ID/EX, the LSU and the load scoreboard.
interface ibex_load_wb_scoreboard_if #(
    parameter int Depth = 2
) ();
    localparam int CntW = $clog2(Depth + 1);
    logic            issue_valid_i;
    logic [4:0]      issue_waddr_i;
    logic            issue_ready_o;
    logic            resp_valid_i;
    logic            resp_err_i;
    logic [4:0]      resp_waddr_o;
    logic            resp_we_o;
    logic [4:0]      rs1_addr_i;
    logic [4:0]      rs2_addr_i;
    logic            rs1_hazard_o;
    logic            rs2_hazard_o;
    logic [CntW-1:0] outstanding_o;
    logic            protocol_err_o;
    modport master (
        output issue_valid_i, issue_waddr_i, resp_valid_i, resp_err_i, rs1_addr_i, rs2_addr_i,
        input  issue_ready_o, resp_waddr_o, resp_we_o, rs1_hazard_o, rs2_hazard_o, outstanding_o,
               protocol_err_o
    );
    modport slave (
        input  issue_valid_i, issue_waddr_i, resp_valid_i, resp_err_i, rs1_addr_i, rs2_addr_i,
        output issue_ready_o, resp_waddr_o, resp_we_o, rs1_hazard_o, rs2_hazard_o, outstanding_o,
               protocol_err_o
    );
endinterface

// File: rtl/ibex_load_wb_scoreboard.sv
// ibex_load_wb_scoreboard: in-order queue of outstanding loads giving RF writeback address/enable and RAW hazards.
module ibex_load_wb_scoreboard #(
    parameter int Depth = 2
) (
    input logic                        clk_i,
    input logic                        rst_ni,
    ibex_load_wb_scoreboard_if.slave   bus
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    logic [Depth-1:0]      valid_q, we_q;
    logic [Depth-1:0][4:0] waddr_q;
    logic [PtrW-1:0]       wp_q, rp_q;
    logic [CntW-1:0]       cnt_q;
    logic                  perr_q;
    logic                  full, empty, iss, ret, h1, h2;
    assign full  = cnt_q == CntW'(Depth);
    assign empty = cnt_q == '0;
    assign iss   = bus.issue_valid_i & ~full;
    assign ret   = bus.resp_valid_i & ~empty;
    assign bus.issue_ready_o  = ~full;
    assign bus.outstanding_o  = cnt_q;
    assign bus.protocol_err_o = perr_q;
    assign bus.resp_waddr_o   = empty ? 5'd0 : waddr_q[rp_q];
    assign bus.resp_we_o      = ret & we_q[rp_q] & ~bus.resp_err_i;
    // Hazards look only at registered entries; a retiring head still counts.
    always_comb begin
        h1 = 1'b0;
        h2 = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            h1 = h1 | (valid_q[i] & we_q[i] & (waddr_q[i] == bus.rs1_addr_i));
            h2 = h2 | (valid_q[i] & we_q[i] & (waddr_q[i] == bus.rs2_addr_i));
        end
        bus.rs1_hazard_o = h1 & (bus.rs1_addr_i != 5'd0);
        bus.rs2_hazard_o = h2 & (bus.rs2_addr_i != 5'd0);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            we_q    <= '0;
            waddr_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            if (ret) valid_q[rp_q] <= 1'b0;
            if (iss) begin
                valid_q[wp_q] <= 1'b1;
                we_q[wp_q]    <= bus.issue_waddr_i != 5'd0;
                waddr_q[wp_q] <= bus.issue_waddr_i;
                wp_q          <= (wp_q == PtrW'(Depth - 1)) ? '0 : wp_q + 1'b1;
            end
            if (ret) rp_q <= (rp_q == PtrW'(Depth - 1)) ? '0 : rp_q + 1'b1;
            cnt_q  <= cnt_q + CntW'(iss) - CntW'(ret);
            perr_q <= (bus.resp_valid_i & empty) | (bus.issue_valid_i & full);
        end
    end
endmodule

// File: tb/tb_ibex_load_wb_scoreboard.sv
// tb_ibex_load_wb_scoreboard: directed vector table plus reset-mid-operation sequence for the load scoreboard.
module tb_ibex_load_wb_scoreboard;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    ibex_load_wb_scoreboard_if #(.Depth(2)) bus ();
    ibex_load_wb_scoreboard #(.Depth(2)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));
    typedef struct packed {
        logic       iv;
        logic [4:0] ia;
        logic       rv;
        logic       re;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       rdy;
        logic [1:0] out;
        logic       we;
        logic [4:0] wa;
        logic       h1;
        logic       h2;
        logic       pe;
    } vec_t;
    vec_t vecs[$];
    function automatic vec_t mk(logic iv, logic [4:0] ia, logic rv, logic re, logic [4:0] r1,
                                logic [4:0] r2, logic rdy, logic [1:0] out, logic we,
                                logic [4:0] wa, logic h1, logic h2, logic pe);
        return '{iv, ia, rv, re, r1, r2, rdy, out, we, wa, h1, h2, pe};
    endfunction
    task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask
    task automatic drive(logic iv, logic [4:0] ia, logic rv, logic re, logic [4:0] r1, logic [4:0] r2);
        bus.issue_valid_i = iv;
        bus.issue_waddr_i = ia;
        bus.resp_valid_i  = rv;
        bus.resp_err_i    = re;
        bus.rs1_addr_i    = r1;
        bus.rs2_addr_i    = r2;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        //          iv ia rv re r1 r2 | rdy out we wa h1 h2 pe
        vecs.push_back(mk(0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 5, 5, 1, 1, 1, 5, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 7, 0, 0, 3, 7, 1, 1, 0, 3, 1, 0, 0));
        vecs.push_back(mk(1, 8, 0, 0, 3, 7, 0, 2, 0, 3, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8, 7, 0, 2, 0, 3, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 3, 0, 0, 2, 1, 3, 1, 0, 0));
        vecs.push_back(mk(1, 4, 1, 0, 3, 4, 1, 1, 1, 7, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 7, 4, 1, 1, 0, 4, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4, 1, 1, 0, 4, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 9, 0, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 9, 0, 1, 1, 0, 9, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_ni = 1'b1;
        step();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].ia, vecs[i].rv, vecs[i].re, vecs[i].r1, vecs[i].r2);
            #3;
            chk($sformatf("v%0d ready", i), 8'(bus.issue_ready_o), 8'(vecs[i].rdy));
            chk($sformatf("v%0d outstanding", i), 8'(bus.outstanding_o), 8'(vecs[i].out));
            chk($sformatf("v%0d resp_we", i), 8'(bus.resp_we_o), 8'(vecs[i].we));
            chk($sformatf("v%0d resp_waddr", i), 8'(bus.resp_waddr_o), 8'(vecs[i].wa));
            chk($sformatf("v%0d rs1_hazard", i), 8'(bus.rs1_hazard_o), 8'(vecs[i].h1));
            chk($sformatf("v%0d rs2_hazard", i), 8'(bus.rs2_hazard_o), 8'(vecs[i].h2));
            chk($sformatf("v%0d protocol_err", i), 8'(bus.protocol_err_o), 8'(vecs[i].pe));
            step();
        end
        // Reset with two loads pending clears state asynchronously.
        drive(1, 5, 0, 0, 5, 6);
        step();
        drive(1, 6, 0, 0, 5, 6);
        step();
        drive(0, 0, 0, 0, 5, 6);
        #2;
        chk("pre_rst outstanding", 8'(bus.outstanding_o), 8'd2);
        chk("pre_rst rs1_hazard", 8'(bus.rs1_hazard_o), 8'd1);
        chk("pre_rst rs2_hazard", 8'(bus.rs2_hazard_o), 8'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst outstanding", 8'(bus.outstanding_o), 8'd0);
        chk("rst ready", 8'(bus.issue_ready_o), 8'd1);
        chk("rst rs1_hazard", 8'(bus.rs1_hazard_o), 8'd0);
        chk("rst rs2_hazard", 8'(bus.rs2_hazard_o), 8'd0);
        chk("rst resp_waddr", 8'(bus.resp_waddr_o), 8'd0);
        step();
        rst_ni = 1'b1;
        step();
        drive(0, 0, 1, 0, 5, 6);
        #3;
        chk("stale resp_we", 8'(bus.resp_we_o), 8'd0);
        chk("stale resp_waddr", 8'(bus.resp_waddr_o), 8'd0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #3;
        chk("stale protocol_err", 8'(bus.protocol_err_o), 8'd1);
        chk("stale outstanding", 8'(bus.outstanding_o), 8'd0);
        step();
        #3;
        chk("stale protocol_err drop", 8'(bus.protocol_err_o), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
